// File: rtl/spi_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_tx_scheduler
// Description : Round-robin scheduler that shares one byte-wide SPI serializer
//               between two cipher-block producers, with header and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_scheduler #(
  parameter int BLOCK_BYTES = 16,
  parameter int HDR_EN      = 1,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [8*BLOCK_BYTES-1:0] req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [8*BLOCK_BYTES-1:0] req1_data,
  output logic                     req1_ready,
  output logic [7:0]               spi_data,
  output logic                     spi_load,
  input  logic                     spi_sent,
  output logic                     busy,
  output logic                     grant_id,
  output logic                     block_done,
  output logic                     timeout_err
);

  localparam int c_DW       = 8 * BLOCK_BYTES;
  localparam int c_NBYTES   = BLOCK_BYTES + ((HDR_EN != 0) ? 1 : 0);
  localparam int c_IDX_W    = $clog2(BLOCK_BYTES + 1);
  localparam int c_WD_W     = $clog2(TIMEOUT + 1);
  localparam int c_GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int c_GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_grant;
  logic               r_grant_id;
  logic [c_IDX_W-1:0] r_idx;
  logic [c_GAP_W-1:0] r_gap;
  logic [c_WD_W-1:0]  r_wd;
  logic [c_DW-1:0]    r_shift;

  logic       w_win;
  logic       w_capture;
  logic       w_is_hdr;
  logic       w_last;
  logic       w_wd_exp;
  logic       w_gap_end;
  logic [7:0] w_byte;

  // Ties go to the requester that did not win last time.
  assign w_win     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  // Gating with rst keeps the ready strobes low while reset is asserted.
  assign w_capture = rst && (r_state == S_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = w_capture && !w_win && req0_valid;
  assign req1_ready = w_capture &&  w_win && req1_valid;

  assign w_is_hdr  = (HDR_EN != 0) && (r_idx == '0);
  assign w_last    = (r_idx == c_IDX_W'(c_NBYTES - 1));
  assign w_wd_exp  = (r_wd == c_WD_W'(TIMEOUT));
  assign w_gap_end = (r_gap == c_GAP_W'(c_GAP_LAST));
  assign w_byte    = w_is_hdr ? (8'hA0 | {7'b0, r_grant_id}) : r_shift[c_DW-1 -: 8];

  assign spi_data  = ((r_state == S_LOAD) || (r_state == S_WAIT)) ? w_byte : 8'h00;
  assign busy      = (r_state != S_IDLE);
  assign grant_id  = r_grant_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    spi_load    = 1'b0;
    block_done  = 1'b0;
    timeout_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_next = S_LOAD;
      end
      S_LOAD: begin
        spi_load = 1'b1;
        w_next   = S_WAIT;
      end
      S_WAIT: begin
        // A completion arriving on the expiry cycle still wins.
        if (spi_sent) begin
          if (w_last)               w_next = S_DONE;
          else if (GAP_CYCLES == 0) w_next = S_LOAD;
          else                      w_next = S_GAP;
        end else if (w_wd_exp) begin
          timeout_err = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_GAP: begin
        if (w_gap_end) w_next = S_LOAD;
      end
      S_DONE: begin
        block_done = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_idx        <= '0;
      r_gap        <= '0;
      r_wd         <= '0;
      r_shift      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_shift      <= w_win ? req1_data : req0_data;
            r_grant_id   <= w_win;
            r_last_grant <= w_win;
            r_idx        <= '0;
          end
        end
        S_LOAD: begin
          r_wd  <= '0;
          r_gap <= '0;
        end
        S_WAIT: begin
          if (spi_sent) begin
            if (!w_last) begin
              r_idx <= r_idx + 1'b1;
              // The header does not consume a data byte.
              if (!w_is_hdr) r_shift <= r_shift << 8;
            end
          end else if (!w_wd_exp) begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_GAP: begin
          r_gap <= r_gap + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_tx_scheduler
// Description : Directed self-checking bench for spi_tx_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_tx_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req0_valid, a_req1_valid, a_req0_ready, a_req1_ready;
  logic [15:0] a_req0_data, a_req1_data;
  logic [7:0]  a_spi_data;
  logic        a_spi_load, a_spi_sent, a_busy, a_grant_id, a_block_done, a_timeout_err;

  logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
  logic [7:0]  b_req0_data, b_req1_data;
  logic [7:0]  b_spi_data;
  logic        b_spi_load, b_spi_sent, b_busy, b_grant_id, b_block_done, b_timeout_err;

  spi_tx_scheduler #(.BLOCK_BYTES(2), .HDR_EN(1), .GAP_CYCLES(2), .TIMEOUT(10)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_ready(a_req1_ready),
    .spi_data(a_spi_data), .spi_load(a_spi_load), .spi_sent(a_spi_sent),
    .busy(a_busy), .grant_id(a_grant_id), .block_done(a_block_done),
    .timeout_err(a_timeout_err)
  );

  spi_tx_scheduler #(.BLOCK_BYTES(1), .HDR_EN(0), .GAP_CYCLES(0), .TIMEOUT(10)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .spi_data(b_spi_data), .spi_load(b_spi_load), .spi_sent(b_spi_sent),
    .busy(b_busy), .grant_id(b_grant_id), .block_done(b_block_done),
    .timeout_err(b_timeout_err)
  );

  int n_chk = 0;
  int n_err = 0;

  int a_r0_cnt = 0, a_r1_cnt = 0, a_done_cnt = 0, a_to_cnt = 0;
  int b_load_cnt = 0, b_done_cnt = 0;

  always @(negedge clk) begin
    if (a_req0_ready)  a_r0_cnt++;
    if (a_req1_ready)  a_r1_cnt++;
    if (a_block_done)  a_done_cnt++;
    if (a_timeout_err) a_to_cnt++;
    if (b_spi_load)    b_load_cnt++;
    if (b_block_done)  b_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serializer model: catch the load, check the byte, pulse spi_sent 8 cycles later.
  task automatic serve_byte(input logic [7:0] exp, input int exp_wait, input string tag);
    int  w;
    bit  seen;
    w    = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (a_spi_load) begin
        w    = i;
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_load_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_data"}, 32'(a_spi_data), 32'(exp));
      if (exp_wait >= 0) check({tag, "_spacing"}, 32'(w), 32'(exp_wait));
      repeat (4) @(negedge clk);
      check({tag, "_held"}, 32'(a_spi_data), 32'(exp));
      repeat (4) @(posedge clk);
      #1 a_spi_sent = 1'b1;
      @(posedge clk);
      #1 a_spi_sent = 1'b0;
    end
  endtask

  task automatic run_block(input logic [7:0] hdr, input logic [7:0] hi, input logic [7:0] lo,
                           input logic gid, input bit drop);
    serve_byte(hdr, -1, "hdr");
    check("grant_id", 32'(a_grant_id), 32'(gid));
    if (drop) begin
      a_req0_valid = 1'b0;
      a_req1_valid = 1'b0;
    end
    serve_byte(hi, 3, "data_hi");
    serve_byte(lo, 3, "data_lo");
    check("block_done", 32'(a_block_done), 32'd1);
    tick();
    check("block_done_pulse", 32'(a_block_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  r0_0, done_0, to_0, to_w;
    bit  seen;

    rst = 1'b0;
    a_req0_valid = 1'b0; a_req1_valid = 1'b0; a_req0_data = '0; a_req1_data = '0;
    a_spi_sent   = 1'b0;
    b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_req0_data = '0; b_req1_data = '0;
    b_spi_sent   = 1'b0;

    // Reset state, including ready suppression while reset is held
    #2;
    a_req0_valid = 1'b1;
    b_req0_valid = 1'b1;
    #1;
    check("rst_busy",       32'(a_busy),        32'd0);
    check("rst_spi_load",   32'(a_spi_load),    32'd0);
    check("rst_spi_data",   32'(a_spi_data),    32'd0);
    check("rst_grant_id",   32'(a_grant_id),    32'd0);
    check("rst_block_done", 32'(a_block_done),  32'd0);
    check("rst_timeout",    32'(a_timeout_err), 32'd0);
    check("rst_ready0",     32'(a_req0_ready),  32'd0);
    check("rst_b_ready0",   32'(b_req0_ready),  32'd0);
    a_req0_valid = 1'b0;
    b_req0_valid = 1'b0;
    tick();
    check("rst_busy_held", 32'(a_busy), 32'd0);
    rst = 1'b1;
    tick();

    // Tie and fairness: 0,1,0,1
    a_req0_data  = 16'h1234;
    a_req1_data  = 16'h5678;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    #1;
    check("tie_ready0", 32'(a_req0_ready), 32'd1);
    check("tie_ready1", 32'(a_req1_ready), 32'd0);
    run_block(8'hA0, 8'h12, 8'h34, 1'b0, 1'b0);
    run_block(8'hA1, 8'h56, 8'h78, 1'b1, 1'b0);
    run_block(8'hA0, 8'h12, 8'h34, 1'b0, 1'b0);
    run_block(8'hA1, 8'h56, 8'h78, 1'b1, 1'b1);
    check("fair_r0_count", 32'(a_r0_cnt), 32'd2);
    check("fair_r1_count", 32'(a_r1_cnt), 32'd2);

    // Single block 0xBEEF from requester 0
    r0_0   = a_r0_cnt;
    done_0 = a_done_cnt;
    a_req0_data  = 16'hBEEF;
    a_req0_valid = 1'b1;
    #1;
    check("single_ready0", 32'(a_req0_ready), 32'd1);
    tick();
    check("single_ready0_low", 32'(a_req0_ready), 32'd0);
    check("single_first_load", 32'(a_spi_load),   32'd1);
    a_req0_valid = 1'b0;
    serve_byte(8'hA0, 1, "single_hdr");
    serve_byte(8'hBE, 3, "single_hi");
    serve_byte(8'hEF, 3, "single_lo");
    check("single_done", 32'(a_block_done), 32'd1);
    tick();
    check("single_ready_cycles", 32'(a_r0_cnt - r0_0),     32'd1);
    check("single_done_count",   32'(a_done_cnt - done_0), 32'd1);
    check("single_idle",         32'(a_busy),              32'd0);

    // Spurious spi_sent in IDLE and in GAP
    a_spi_sent = 1'b1;
    tick();
    a_spi_sent = 1'b0;
    check("spur_idle_busy", 32'(a_busy), 32'd0);
    a_req0_data  = 16'hC33C;
    a_req0_valid = 1'b1;
    serve_byte(8'hA0, -1, "spur_hdr");
    a_req0_valid = 1'b0;
    a_spi_sent = 1'b1;
    tick();
    a_spi_sent = 1'b0;
    serve_byte(8'hC3, 2, "spur_hi");
    serve_byte(8'h3C, 3, "spur_lo");
    check("spur_done", 32'(a_block_done), 32'd1);
    tick();

    // Watchdog timeout with a silent serializer
    done_0 = a_done_cnt;
    to_0   = a_to_cnt;
    a_req0_data  = 16'h1111;
    a_req0_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_spi_load) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_load_seen", 32'(seen), 32'd1);
    a_req0_valid = 1'b0;
    to_w = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (a_timeout_err) begin
        to_w = i;
        break;
      end
    end
    check("to_latency", 32'(to_w), 32'd11);
    @(negedge clk);
    check("to_idle",       32'(a_busy),              32'd0);
    check("to_pulse",      32'(a_timeout_err),       32'd0);
    check("to_count",      32'(a_to_cnt - to_0),     32'd1);
    check("to_no_done",    32'(a_done_cnt - done_0), 32'd0);
    a_req1_data  = 16'h9ABC;
    a_req1_valid = 1'b1;
    serve_byte(8'hA1, -1, "after_to_hdr");
    a_req1_valid = 1'b0;
    serve_byte(8'h9A, 3, "after_to_hi");
    serve_byte(8'hBC, 3, "after_to_lo");
    check("after_to_done", 32'(a_block_done), 32'd1);
    tick();

    // Reset during WAIT of byte 2
    a_req0_data  = 16'hDEAD;
    a_req0_valid = 1'b1;
    serve_byte(8'hA0, -1, "rstmid_hdr");
    a_req0_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_spi_load) begin
        seen = 1'b1;
        break;
      end
    end
    check("rstmid_load_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check("rstmid_wait_data", 32'(a_spi_data), 32'hDE);
    done_0 = a_done_cnt;
    to_0   = a_to_cnt;
    #2;
    rst          = 1'b0;
    a_req1_data  = 16'h0F0F;
    a_req1_valid = 1'b1;
    #1;
    check("rstmid_busy",     32'(a_busy),        32'd0);
    check("rstmid_spi_data", 32'(a_spi_data),    32'd0);
    check("rstmid_spi_load", 32'(a_spi_load),    32'd0);
    check("rstmid_grant",    32'(a_grant_id),    32'd0);
    check("rstmid_done",     32'(a_block_done),  32'd0);
    check("rstmid_timeout",  32'(a_timeout_err), 32'd0);
    check("rstmid_ready1",   32'(a_req1_ready),  32'd0);
    tick();
    rst = 1'b1;
    check("rstmid_no_done_pulse", 32'(a_done_cnt - done_0), 32'd0);
    check("rstmid_no_to_pulse",   32'(a_to_cnt - to_0),     32'd0);
    serve_byte(8'hA1, -1, "rstmid_new_hdr");
    a_req1_valid = 1'b0;
    check("rstmid_new_grant", 32'(a_grant_id), 32'd1);
    serve_byte(8'h0F, 3, "rstmid_new_hi");
    serve_byte(8'h0F, 3, "rstmid_new_lo");
    check("rstmid_new_done", 32'(a_block_done), 32'd1);
    tick();

    // Edge configuration: one byte, no header, no gap
    b_req0_data  = 8'h5A;
    b_req0_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_spi_load) begin
        seen = 1'b1;
        break;
      end
    end
    check("edge_load_seen", 32'(seen),       32'd1);
    check("edge_data",      32'(b_spi_data), 32'h5A);
    check("edge_grant",     32'(b_grant_id), 32'd0);
    b_req0_valid = 1'b0;
    tick();
    tick();
    b_spi_sent = 1'b1;
    tick();
    b_spi_sent = 1'b0;
    check("edge_done",       32'(b_block_done), 32'd1);
    check("edge_no_reload",  32'(b_spi_load),   32'd0);
    tick();
    check("edge_done_pulse", 32'(b_block_done), 32'd0);
    check("edge_idle",       32'(b_busy),       32'd0);
    check("edge_load_count", 32'(b_load_cnt),   32'd1);
    check("edge_done_count", 32'(b_done_cnt),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_tx_scheduler.md
Name: spi_tx_scheduler

Overview:
- Shares the single byte-wide SPI output serializer between two crypto result producers, e.g. the encrypt and decrypt paths.
- Arbitrates round-robin and captures one whole cipher block from the winner.
- Streams the block to the serializer one byte at a time: an optional header byte first, then data MSB-first, waiting on the serializer's per-byte completion pulse.
- Provides a watchdog abort and sits between the cipher cores and the SPI output stage.

Parameters:
- BLOCK_BYTES, 16, bytes per cipher block (128-bit block); legal range 1..32.
- HDR_EN, 1, 1 = send the header byte 0xA0|grant_id before the data bytes.
- GAP_CYCLES, 2, idle cycles between a byte's spi_sent and the next spi_load; 0 is legal.
- TIMEOUT, 255, maximum cycles to wait for spi_sent before aborting the block.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a block.
- req0_data  in  8*BLOCK_BYTES  requester 0 block.
- req0_ready  out  1  block-0 capture strobe.
- req1_valid  in  1  requester 1 has a block.
- req1_data  in  8*BLOCK_BYTES  requester 1 block.
- req1_ready  out  1  block-1 capture strobe.
- spi_data  out  8  byte to the serializer.
- spi_load  out  1  one-cycle strobe: serializer takes spi_data.
- spi_sent  in  1  one-cycle pulse from the serializer: byte fully shifted out.
- busy  out  1  high in any state except IDLE.
- grant_id  out  1  requester owning the current block.
- block_done  out  1  one-cycle pulse: last byte's spi_sent received.
- timeout_err  out  1  one-cycle pulse: block aborted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; every output is 0.
  - last_grant=1, so requester 0 wins the first tie.
  - Byte index, gap counter and watchdog counter are 0.
- States: IDLE, LOAD, WAIT, GAP, DONE.
- IDLE:
  - Winner: the single valid requester; if both are valid, the one opposite last_grant.
  - reqN_ready is combinational, (state==IDLE)&&winner==N&&reqN_valid; it is high in at most one cycle per block.
  - On that edge: block captured into the shift register, grant_id and last_grant updated, byte index cleared, next state LOAD.
  - Requesters must hold valid/data until ready is seen.
- LOAD: spi_load=1 for exactly one cycle with spi_data valid; next state WAIT; watchdog cleared.
- spi_data:
  - If HDR_EN, the first byte is 8'hA0|{7'b0,grant_id}.
  - Then bytes [8*BLOCK_BYTES-1 -: 8] down to [7:0].
  - spi_data is held stable from LOAD until leaving WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On spi_sent: if the byte just sent was the last, go to DONE; else advance the byte index and go to GAP (or directly to LOAD when GAP_CYCLES=0).
  - spi_sent in any state other than WAIT is ignored.
  - If the watchdog reaches TIMEOUT without spi_sent: timeout_err pulses, the block is discarded, next state IDLE.
  - spi_sent in the same cycle the watchdog reaches TIMEOUT counts as success; no error.
- GAP: count GAP_CYCLES cycles, then go to LOAD.
- DONE: block_done=1 for one cycle; next state IDLE.
  - A new block can be granted in the cycle after DONE, so minimum back-to-back spacing is 1 idle cycle.
- Bytes per block = BLOCK_BYTES+HDR_EN.
- Latency: the spi_load of the first byte is the cycle after the ready handshake.
- New requests arriving during a transfer are not acknowledged until IDLE; no preemption.
- Reset mid-transfer: immediate return to reset values. The partial block is lost; no block_done or timeout_err is produced.
- Register widths:
  - Byte index: $clog2(BLOCK_BYTES+1) bits.
  - Watchdog: $clog2(TIMEOUT+1) bits.
  - Gap counter: $clog2(GAP_CYCLES+1) bits, or a 1-bit minimum.

Test Plan:
- Single block: BLOCK_BYTES=2, HDR_EN=1; req0 data 0xBEEF; serializer model asserts spi_sent 8 cycles after each load. Required: spi_load pulses with spi_data 0xA0, 0xBE, 0xEF in that order, each at least 2 cycles after the previous spi_sent; block_done once; req0_ready high exactly 1 cycle.
- Tie and fairness: req0 and req1 are both valid, and each re-asserts valid immediately after every capture. Required: grant order 0,1,0,1; headers 0xA0, 0xA1, 0xA0, 0xA1.
- Timeout: TIMEOUT=10, serializer never pulses. Required: timeout_err exactly 11 cycles after the first spi_load; state IDLE; no block_done; the next request is served normally.
- Spurious sent: spi_sent pulsed while in IDLE and in GAP. Required: no change in byte index or byte output order.
- Reset mid-block: rst=0 during WAIT of byte 2. Required: all outputs 0 asynchronously, before the next clock edge. After release, a fresh req1 block sends header 0xA1 first.
- Edge configuration: HDR_EN=0, GAP_CYCLES=0, BLOCK_BYTES=1, data 0x5A. Required: single spi_load with 0x5A; block_done the cycle after spi_sent.
